// File: rtl/exec_stage_if.sv
// Data-memory request/response bus between the execute stage and data memory.
// The execute stage is the master; memory returns read data one cycle after a read request.
interface exec_stage_if;
    logic        dmem_rready;
    logic        dmem_wready;
    logic [31:0] dmem_raddr;
    logic [31:0] dmem_waddr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_rready, dmem_wready, dmem_raddr, dmem_waddr, dmem_wdata, dmem_wstrb,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_rready, dmem_wready, dmem_raddr, dmem_waddr, dmem_wdata, dmem_wstrb,
        output dmem_rdata
    );
endinterface

// File: rtl/exec_stage.sv
// RV32I execute stage: ALU, branch/jump resolution, dmem requests, EX->WB registers, load align.
// Define EXEC_CSR_COUNTER_EN to build the 64-bit cycle counter read by CSR instructions.
module exec_stage (
    input  logic        clk,
    input  logic        resetb,
    input  logic [31:0] ex_src1,
    input  logic [31:0] ex_src2,
    input  logic [31:0] ex_imm,
    input  logic        ex_imm_sel,
    input  logic        ex_alu,
    input  logic        ex_lui,
    input  logic        ex_auipc,
    input  logic        ex_jal,
    input  logic        ex_jalr,
    input  logic        ex_csr,
    input  logic        ex_branch,
    input  logic        ex_memwr,
    input  logic        ex_mem2reg,
    input  logic [2:0]  ex_alu_op,
    input  logic        ex_subtype,
    input  logic [31:0] ex_pc,
    input  logic [4:0]  ex_dst_sel,
    output logic        ex_redirect,
    output logic [31:0] ex_target,
    exec_stage_if.master dmem,
    output logic [31:0] wb_result,
    output logic        wb_alu2reg,
    output logic        wb_mem2reg,
    output logic        wb_memwr,
    output logic [4:0]  wb_dst_sel,
    output logic [1:0]  wb_raddr,
    output logic [2:0]  wb_alu_op,
    output logic [31:0] wb_waddr,
    output logic [31:0] wb_wdata,
    output logic [3:0]  wb_wstrb,
    output logic [31:0] wb_load_data
);
    logic [31:0] op_b, alu_res, mem_addr, csr_val;
    logic [4:0]  shamt;
    logic        taken, store_req;
    logic [31:0] st_data;
    logic [3:0]  st_strb;

    logic [31:0] wb_result_d, wb_result_q, wb_waddr_d, wb_waddr_q, wb_wdata_d, wb_wdata_q;
    logic        wb_alu2reg_d, wb_alu2reg_q, wb_mem2reg_d, wb_mem2reg_q, wb_memwr_d, wb_memwr_q;
    logic [4:0]  wb_dst_sel_d, wb_dst_sel_q;
    logic [1:0]  wb_raddr_d, wb_raddr_q;
    logic [2:0]  wb_alu_op_d, wb_alu_op_q;
    logic [3:0]  wb_wstrb_d, wb_wstrb_q;

`ifdef EXEC_CSR_COUNTER_EN
    logic [63:0] cycle_d, cycle_q;

    always_comb cycle_d = cycle_q + 64'd1;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) cycle_q <= '0;
        else         cycle_q <= cycle_d;
    end

    // imm[7] distinguishes rdcycleh (0xC80) from rdcycle (0xC00)
    assign csr_val = ex_imm[7] ? cycle_q[63:32] : cycle_q[31:0];
`else
    assign csr_val = '0;
`endif

    always_comb begin
        op_b     = ex_imm_sel ? ex_imm : ex_src2;
        shamt    = op_b[4:0];
        mem_addr = ex_src1 + ex_imm;
        unique case (ex_alu_op)
            3'b000: alu_res = (ex_subtype && !ex_imm_sel) ? ex_src1 - op_b : ex_src1 + op_b;
            3'b001: alu_res = ex_src1 << shamt;
            3'b010: alu_res = {31'd0, $signed(ex_src1) < $signed(op_b)};
            3'b011: alu_res = {31'd0, ex_src1 < op_b};
            3'b100: alu_res = ex_src1 ^ op_b;
            3'b101: alu_res = ex_subtype ? $unsigned($signed(ex_src1) >>> shamt)
                                         : ex_src1 >> shamt;
            3'b110: alu_res = ex_src1 | op_b;
            3'b111: alu_res = ex_src1 & op_b;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (ex_alu_op)
            3'b000:  taken = ex_src1 == ex_src2;
            3'b001:  taken = ex_src1 != ex_src2;
            3'b100:  taken = $signed(ex_src1) < $signed(ex_src2);
            3'b101:  taken = !($signed(ex_src1) < $signed(ex_src2));
            3'b110:  taken = ex_src1 < ex_src2;
            3'b111:  taken = !(ex_src1 < ex_src2);
            default: taken = 1'b0;
        endcase
        ex_redirect = ex_jal || ex_jalr || (ex_branch && taken);
        if (ex_jalr)          ex_target = mem_addr & ~32'd1;
        else if (ex_redirect) ex_target = ex_pc + ex_imm;
        else                  ex_target = '0;
    end

    always_comb begin
        case (ex_alu_op[1:0])
            2'b00: begin
                st_strb = 4'b0001 << mem_addr[1:0];
                st_data = {4{ex_src2[7:0]}};
            end
            2'b01: begin
                st_strb = mem_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{ex_src2[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = ex_src2;
            end
        endcase
    end

    // A store still in EX while reset is asserted must never reach memory
    assign store_req        = ex_memwr && resetb;
    assign dmem.dmem_wready = store_req;
    assign dmem.dmem_waddr  = store_req ? mem_addr : '0;
    assign dmem.dmem_wdata  = store_req ? st_data : '0;
    assign dmem.dmem_wstrb  = store_req ? st_strb : '0;
    assign dmem.dmem_rready = ex_mem2reg;
    assign dmem.dmem_raddr  = ex_mem2reg ? mem_addr : '0;

    always_comb begin
        if (ex_lui)                wb_result_d = ex_imm;
        else if (ex_auipc)         wb_result_d = ex_pc + ex_imm;
        else if (ex_jal | ex_jalr) wb_result_d = ex_pc + 32'd4;
        else if (ex_csr)           wb_result_d = csr_val;
        else                       wb_result_d = alu_res;
        wb_alu2reg_d = (ex_alu | ex_lui | ex_auipc | ex_jal | ex_jalr | ex_csr)
                       && (ex_dst_sel != 5'd0);
        wb_mem2reg_d = ex_mem2reg && (ex_dst_sel != 5'd0);
        wb_memwr_d   = ex_memwr;
        wb_dst_sel_d = ex_dst_sel;
        wb_raddr_d   = mem_addr[1:0];
        wb_alu_op_d  = ex_alu_op;
        wb_waddr_d   = dmem.dmem_waddr;
        wb_wdata_d   = dmem.dmem_wdata;
        wb_wstrb_d   = dmem.dmem_wstrb;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wb_result_q  <= '0;
            wb_alu2reg_q <= 1'b0;
            wb_mem2reg_q <= 1'b0;
            wb_memwr_q   <= 1'b0;
            wb_dst_sel_q <= '0;
            wb_raddr_q   <= '0;
            wb_alu_op_q  <= '0;
            wb_waddr_q   <= '0;
            wb_wdata_q   <= '0;
            wb_wstrb_q   <= '0;
        end else begin
            wb_result_q  <= wb_result_d;
            wb_alu2reg_q <= wb_alu2reg_d;
            wb_mem2reg_q <= wb_mem2reg_d;
            wb_memwr_q   <= wb_memwr_d;
            wb_dst_sel_q <= wb_dst_sel_d;
            wb_raddr_q   <= wb_raddr_d;
            wb_alu_op_q  <= wb_alu_op_d;
            wb_waddr_q   <= wb_waddr_d;
            wb_wdata_q   <= wb_wdata_d;
            wb_wstrb_q   <= wb_wstrb_d;
        end
    end

    assign wb_result  = wb_result_q;
    assign wb_alu2reg = wb_alu2reg_q;
    assign wb_mem2reg = wb_mem2reg_q;
    assign wb_memwr   = wb_memwr_q;
    assign wb_dst_sel = wb_dst_sel_q;
    assign wb_raddr   = wb_raddr_q;
    assign wb_alu_op  = wb_alu_op_q;
    assign wb_waddr   = wb_waddr_q;
    assign wb_wdata   = wb_wdata_q;
    assign wb_wstrb   = wb_wstrb_q;

    logic [31:0] ld_shift;
    logic [15:0] ld_half;

    always_comb begin
        ld_shift = dmem.dmem_rdata >> {wb_raddr_q, 3'b000};
        ld_half  = wb_raddr_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (wb_alu_op_q)
            3'b000:  wb_load_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  wb_load_data = {24'd0, ld_shift[7:0]};
            3'b001:  wb_load_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  wb_load_data = {16'd0, ld_half};
            default: wb_load_data = dmem.dmem_rdata;
        endcase
    end
endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed cases plus random instructions against a model.
module tb_exec_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetb;
    logic [31:0] ex_src1, ex_src2, ex_imm, ex_pc;
    logic        ex_imm_sel, ex_subtype;
    logic        ex_alu, ex_lui, ex_auipc, ex_jal, ex_jalr, ex_csr, ex_branch;
    logic        ex_memwr, ex_mem2reg;
    logic [2:0]  ex_alu_op;
    logic [4:0]  ex_dst_sel;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic [31:0] wb_result, wb_waddr, wb_wdata, wb_load_data;
    logic        wb_alu2reg, wb_mem2reg, wb_memwr;
    logic [4:0]  wb_dst_sel;
    logic [1:0]  wb_raddr;
    logic [2:0]  wb_alu_op;
    logic [3:0]  wb_wstrb;

    exec_stage_if bus ();

    exec_stage dut (
        .clk(clk), .resetb(resetb),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_imm(ex_imm), .ex_imm_sel(ex_imm_sel),
        .ex_alu(ex_alu), .ex_lui(ex_lui), .ex_auipc(ex_auipc), .ex_jal(ex_jal),
        .ex_jalr(ex_jalr), .ex_csr(ex_csr), .ex_branch(ex_branch), .ex_memwr(ex_memwr),
        .ex_mem2reg(ex_mem2reg), .ex_alu_op(ex_alu_op), .ex_subtype(ex_subtype),
        .ex_pc(ex_pc), .ex_dst_sel(ex_dst_sel),
        .ex_redirect(ex_redirect), .ex_target(ex_target),
        .dmem(bus),
        .wb_result(wb_result), .wb_alu2reg(wb_alu2reg), .wb_mem2reg(wb_mem2reg),
        .wb_memwr(wb_memwr), .wb_dst_sel(wb_dst_sel), .wb_raddr(wb_raddr),
        .wb_alu_op(wb_alu_op), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .wb_wstrb(wb_wstrb), .wb_load_data(wb_load_data)
    );

    // Instruction classes: 0 bubble, 1 alu, 2 lui, 3 auipc, 4 jal, 5 jalr, 6 csr,
    // 7 branch, 8 store, 9 load
    typedef struct {
        int          cls;
        logic [2:0]  f3;
        logic        sub;
        logic        isel;
        logic [31:0] s1, s2, imm, pc;
        logic [4:0]  rd;
    } insn_t;

    typedef struct {
        logic        redirect;
        logic [31:0] target;
        logic        rready, wready;
        logic [31:0] raddr, waddr, wdata;
        logic [3:0]  wstrb;
        logic        has_result;
        logic [31:0] result;
        logic        alu2reg, mem2reg, memwr;
        logic [1:0]  off;
    } exp_t;

    int n_cmp = 0;
    int n_err = 0;

    longint unsigned cyc_ref;
    always @(posedge clk or negedge resetb) begin
        if (!resetb) cyc_ref <= 0;
        else         cyc_ref <= cyc_ref + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic insn_t mk(input int cls, input logic [2:0] f3, input logic sub,
                                 input logic isel, input logic [31:0] s1, input logic [31:0] s2,
                                 input logic [31:0] imm, input logic [31:0] pc,
                                 input logic [4:0] rd);
        insn_t i;
        i.cls = cls; i.f3 = f3; i.sub = sub; i.isel = isel;
        i.s1 = s1; i.s2 = s2; i.imm = imm; i.pc = pc; i.rd = rd;
        return i;
    endfunction

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    function automatic exp_t model(input insn_t i, input longint unsigned cyc);
        exp_t        e;
        logic [31:0] b, addr, alu;
        int          sh, lane;
        logic        tk;
        b    = i.isel ? i.imm : i.s2;
        sh   = int'(b % 32);
        addr = i.s1 + i.imm;
        lane = int'(addr % 4);
        case (i.f3)
            3'd0: alu = (i.sub && !i.isel) ? i.s1 - b : i.s1 + b;
            3'd1: alu = 32'(i.s1 << sh);
            3'd2: alu = (sx(i.s1) < sx(b)) ? 32'd1 : 32'd0;
            3'd3: alu = (i.s1 < b) ? 32'd1 : 32'd0;
            3'd4: alu = i.s1 ^ b;
            3'd5: alu = i.sub ? 32'(sx(i.s1) >>> sh) : i.s1 >> sh;
            3'd6: alu = i.s1 | b;
            default: alu = i.s1 & b;
        endcase
        case (i.f3)
            3'd0: tk = i.s1 == i.s2;
            3'd1: tk = i.s1 != i.s2;
            3'd4: tk = sx(i.s1) < sx(i.s2);
            3'd5: tk = sx(i.s1) >= sx(i.s2);
            3'd6: tk = i.s1 < i.s2;
            3'd7: tk = i.s1 >= i.s2;
            default: tk = 1'b0;
        endcase
        e.redirect = (i.cls == 4) || (i.cls == 5) || (i.cls == 7 && tk);
        if (i.cls == 5)      e.target = {addr[31:1], 1'b0};
        else if (e.redirect) e.target = i.pc + i.imm;
        else                 e.target = 32'd0;
        e.rready = (i.cls == 9);
        e.raddr  = e.rready ? addr : 32'd0;
        e.wready = (i.cls == 8);
        e.waddr  = 32'd0; e.wdata = 32'd0; e.wstrb = 4'd0;
        if (e.wready) begin
            e.waddr = addr;
            if (i.f3 == 3'd0) begin
                e.wstrb = 4'(1 << lane);
                e.wdata = {4{i.s2[7:0]}};
            end else if (i.f3 == 3'd1) begin
                e.wstrb = 4'(3 << (2 * (lane / 2)));
                e.wdata = {2{i.s2[15:0]}};
            end else begin
                e.wstrb = 4'hF;
                e.wdata = i.s2;
            end
        end
        e.has_result = (i.cls >= 1 && i.cls <= 6);
        case (i.cls)
            2:       e.result = i.imm;
            3:       e.result = i.pc + i.imm;
            4, 5:    e.result = i.pc + 32'd4;
            6:       e.result = i.imm[7] ? cyc[63:32] : cyc[31:0];
            default: e.result = alu;
        endcase
        e.alu2reg = e.has_result && (i.rd != 0);
        e.mem2reg = (i.cls == 9) && (i.rd != 0);
        e.memwr   = (i.cls == 8);
        e.off     = addr[1:0];
        return e;
    endfunction

    function automatic logic [31:0] align(input logic [31:0] rd, input int off, input logic [2:0] f3);
        longint v;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = longint'((rd >> (8 * off)) & 32'hFF);
            if (f3 == 3'd0 && v > 127) v = v - 256;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            v = longint'((rd >> (8 * (off & 2))) & 32'hFFFF);
            if (f3 == 3'd1 && v > 32767) v = v - 65536;
        end else begin
            v = longint'(rd);
        end
        return 32'(v);
    endfunction

    function automatic longint unsigned cyc_now();
`ifdef EXEC_CSR_COUNTER_EN
        return cyc_ref;
`else
        return 64'd0;
`endif
    endfunction

    task automatic apply(input insn_t i);
        ex_src1 = i.s1; ex_src2 = i.s2; ex_imm = i.imm; ex_pc = i.pc;
        ex_imm_sel = i.isel; ex_subtype = i.sub; ex_alu_op = i.f3; ex_dst_sel = i.rd;
        ex_alu = (i.cls == 1); ex_lui = (i.cls == 2); ex_auipc = (i.cls == 3);
        ex_jal = (i.cls == 4); ex_jalr = (i.cls == 5); ex_csr = (i.cls == 6);
        ex_branch = (i.cls == 7); ex_memwr = (i.cls == 8); ex_mem2reg = (i.cls == 9);
    endtask

    // Drive one instruction through EX, check combinational outputs, then the WB registers
    task automatic run(input insn_t i, input logic [31:0] rdata);
        exp_t e;
        apply(i);
        #1;
        e = model(i, cyc_now());
        chk("redirect", ex_redirect, e.redirect);
        chk("target", ex_target, e.target);
        chk("rready", bus.dmem_rready, e.rready);
        chk("raddr", bus.dmem_raddr, e.raddr);
        chk("wready", bus.dmem_wready, e.wready);
        chk("waddr", bus.dmem_waddr, e.waddr);
        chk("wdata", bus.dmem_wdata, e.wdata);
        chk("wstrb", bus.dmem_wstrb, e.wstrb);
        @(posedge clk);
        #1;
        chk("wb_alu2reg", wb_alu2reg, e.alu2reg);
        chk("wb_mem2reg", wb_mem2reg, e.mem2reg);
        chk("wb_memwr", wb_memwr, e.memwr);
        chk("wb_dst_sel", wb_dst_sel, i.rd);
        chk("wb_alu_op", wb_alu_op, i.f3);
        chk("wb_waddr", wb_waddr, e.waddr);
        chk("wb_wdata", wb_wdata, e.wdata);
        chk("wb_wstrb", wb_wstrb, e.wstrb);
        if (e.has_result) chk("wb_result", wb_result, e.result);
        bus.dmem_rdata = rdata;
        #1;
        if (i.cls == 9) begin
            chk("wb_raddr", wb_raddr, e.off);
            chk("wb_load_data", wb_load_data, align(rdata, int'(e.off), i.f3));
        end
    endtask

    logic [2:0] ld_ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        insn_t i;
        resetb = 1'b0;
        bus.dmem_rdata = 32'd0;
        apply(mk(0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0));
        #1;
        chk("rst_wb_result", wb_result, 32'd0);
        chk("rst_wb_alu2reg", wb_alu2reg, 1'b0);
        chk("rst_wb_memwr", wb_memwr, 1'b0);
        chk("rst_wb_wstrb", wb_wstrb, 4'd0);
        #11;
        resetb = 1'b1;

        run(mk(1, 3'd0, 1'b0, 1'b1, 32'd5, 32'd0, 32'hFFFFFFF9, 32'h100, 5'd1), 32'd0);
        chk("addi_const", wb_result, 32'hFFFFFFFE);
        chk("addi_alu2reg", wb_alu2reg, 1'b1);
        run(mk(1, 3'd0, 1'b1, 1'b0, 32'd3, 32'd5, 32'd0, 32'h104, 5'd2), 32'd0);
        chk("sub_const", wb_result, 32'hFFFFFFFE);
        run(mk(1, 3'd5, 1'b1, 1'b1, 32'h80000000, 32'd0, 32'd4, 32'h108, 5'd3), 32'd0);
        chk("sra_const", wb_result, 32'hF8000000);
        run(mk(1, 3'd5, 1'b0, 1'b1, 32'h80000000, 32'd0, 32'd4, 32'h10C, 5'd3), 32'd0);
        chk("srl_const", wb_result, 32'h08000000);

        i = mk(8, 3'd0, 1'b0, 1'b1, 32'h1000, 32'h12345678, 32'd3, 32'h110, 5'd0);
        apply(i);
        #1;
        chk("sb_wstrb_const", bus.dmem_wstrb, 4'h8);
        chk("sb_wdata_const", bus.dmem_wdata, 32'h78787878);
        run(i, 32'd0);
        i = mk(8, 3'd2, 1'b0, 1'b1, 32'h80000000, 32'hCAFEBABE, 32'h1C, 32'h114, 5'd0);
        apply(i);
        #1;
        chk("sw_wstrb_const", bus.dmem_wstrb, 4'hF);
        run(i, 32'd0);

        run(mk(9, 3'd0, 1'b0, 1'b1, 32'h2000, 32'd0, 32'd2, 32'h118, 5'd4), 32'h0080FF00);
        chk("lb_const", wb_load_data, 32'hFFFFFF80);
        run(mk(9, 3'd4, 1'b0, 1'b1, 32'h2000, 32'd0, 32'd2, 32'h11C, 5'd4), 32'h0080FF00);
        chk("lbu_const", wb_load_data, 32'h00000080);

        i = mk(7, 3'd4, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h400, 5'd0);
        apply(i);
        #1;
        chk("blt_taken_const", ex_redirect, 1'b1);
        chk("blt_target_const", ex_target, 32'h420);
        run(i, 32'd0);
        i = mk(7, 3'd6, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h400, 5'd0);
        apply(i);
        #1;
        chk("bltu_nt_const", ex_redirect, 1'b0);
        run(i, 32'd0);
        i = mk(5, 3'd0, 1'b0, 1'b1, 32'h101, 32'd0, 32'd0, 32'h200, 5'd1);
        apply(i);
        #1;
        chk("jalr_target_const", ex_target, 32'h100);
        run(i, 32'd0);
        chk("jalr_link_const", wb_result, 32'h204);

        // Reset in the middle of a store: write strobe and WB state drop at once
        run(mk(1, 3'd0, 1'b0, 1'b1, 32'd9, 32'd0, 32'd1, 32'h300, 5'd7), 32'd0);
        apply(mk(8, 3'd2, 1'b0, 1'b1, 32'h40, 32'h55AA55AA, 32'd4, 32'h304, 5'd0));
        #1;
        chk("pre_rst_wready", bus.dmem_wready, 1'b1);
        resetb = 1'b0;
        #1;
        chk("mid_rst_wready", bus.dmem_wready, 1'b0);
        chk("mid_rst_wb_result", wb_result, 32'd0);
        chk("mid_rst_wb_alu2reg", wb_alu2reg, 1'b0);
        chk("mid_rst_wb_dst", wb_dst_sel, 5'd0);
        apply(mk(0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0));
        @(posedge clk);
        #1;
        chk("rst_hold_wb_memwr", wb_memwr, 1'b0);
        resetb = 1'b1;
        #1;

        for (int n = 0; n < 400; n++) begin
            i.cls  = int'($urandom_range(0, 9));
            i.f3   = 3'($urandom_range(0, 7));
            i.sub  = 1'($urandom_range(0, 1));
            i.isel = 1'($urandom_range(0, 1));
            i.s1   = $urandom;
            i.s2   = ($urandom_range(0, 3) == 0) ? i.s1 : $urandom;
            i.imm  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            i.pc   = $urandom & 32'hFFFFFFFC;
            i.rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if (i.cls == 8) i.f3 = 3'($urandom_range(0, 2));
            if (i.cls == 9) i.f3 = ld_ops[$urandom_range(0, 4)];
            run(i, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
